// File: rtl/fc_wgt_packer.sv
// FC weight packer: reads byte-wide weights from SRAM, packs LANES of them per word and
// hands packed words to the FC engine through a small show-ahead FIFO.
module fc_wgt_packer #(
   parameter int WEIGHT_WIDTH = 8,
   parameter int LANES        = 8,
   parameter int IN_FEATURE   = 360,
   parameter int OUT_FEATURE  = 160,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                          clk2,
   input  logic                          rst_n,
   input  logic                          start,
   output logic                          mem_rd,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic [WEIGHT_WIDTH-1:0]       mem_rdata,
   input  logic                          wgt_read,
   output logic [LANES*WEIGHT_WIDTH-1:0] wgt_out,
   output logic                          wgt_valid,
   output logic                          busy,
   output logic                          done,
   output logic                          underflow
);
   localparam int TOTAL = IN_FEATURE * OUT_FEATURE;
   localparam int WORDS = TOTAL / LANES;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = PW + 1;
   localparam int SW    = CW + 1;
   localparam int WW    = $clog2(WORDS + 1);

   generate
      if (TOTAL % LANES != 0) begin : g_bad_lanes
         $error("IN_FEATURE*OUT_FEATURE must be a multiple of LANES");
      end
      if ((2 ** ADDR_WIDTH) < TOTAL) begin : g_bad_addr
         $error("ADDR_WIDTH too small for IN_FEATURE*OUT_FEATURE");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t                                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
   logic [LW-1:0]                          lane_q, lane_d;
   logic [WW-1:0]                          popped_q, popped_d;
   logic [CW-1:0]                          count_q;
   logic [PW-1:0]                          wr_ptr_q, rd_ptr_q;
   logic [1:0]                             inasm_q;
   logic                                   rd_pend_q;
   logic [LW-1:0]                          cap_lane_q;
   logic [LANES-1:0][WEIGHT_WIDTH-1:0]     asm_q, push_word;
   logic [LANES*WEIGHT_WIDTH-1:0]          fifo_mem [FIFO_DEPTH];
   logic                                   underflow_q;
   logic                                   credit_ok, issue0, push, pop;

   // Words still being assembled hold a FIFO slot, so a push never finds the FIFO full.
   assign credit_ok = (SW'(count_q) + SW'(inasm_q)) < SW'(FIFO_DEPTH);
   assign mem_rd    = (state_q == S_FETCH) && ((lane_q != '0) || credit_ok);
   assign mem_addr  = mem_rd ? addr_q : '0;
   assign issue0    = mem_rd && (lane_q == '0);
   assign push      = rd_pend_q && (cap_lane_q == LW'(LANES - 1));
   assign wgt_valid = (count_q != '0);
   assign pop       = wgt_read && wgt_valid;
   assign wgt_out   = wgt_valid ? fifo_mem[rd_ptr_q] : '0;
   assign busy      = (state_q != S_IDLE);
   assign underflow = underflow_q;

   always_comb begin
      push_word             = asm_q;
      push_word[cap_lane_q] = mem_rdata;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      lane_d   = lane_q;
      popped_d = popped_q;
      done     = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: if (mem_rd) begin
            if (addr_q == ADDR_WIDTH'(TOTAL - 1)) begin
               addr_d  = '0;
               state_d = S_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
            lane_d = (lane_q == LW'(LANES - 1)) ? '0 : lane_q + 1'b1;
         end
         S_DRAIN: ;
         default: state_d = S_IDLE;
      endcase
      // The final pop can only happen after the last read, i.e. in DRAIN.
      if (pop) begin
         if (popped_q == WW'(WORDS - 1)) begin
            popped_d = '0;
            done     = 1'b1;
            state_d  = S_IDLE;
         end else begin
            popped_d = popped_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         lane_q      <= '0;
         popped_q    <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         inasm_q     <= '0;
         rd_pend_q   <= 1'b0;
         cap_lane_q  <= '0;
         asm_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         lane_q     <= lane_d;
         popped_q   <= popped_d;
         rd_pend_q  <= mem_rd;
         cap_lane_q <= lane_q;
         if (rd_pend_q) asm_q[cap_lane_q] <= mem_rdata;
         case ({issue0, push})
            2'b10:   inasm_q <= inasm_q + 1'b1;
            2'b01:   inasm_q <= inasm_q - 1'b1;
            default: inasm_q <= inasm_q;
         endcase
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wgt_read && !wgt_valid) underflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk2) begin
      if (push) fifo_mem[wr_ptr_q] <= push_word;
   end

   a_no_push_full: assert property (@(posedge clk2) disable iff (!rst_n)
      !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule
